decode: RTL and testbench



---
 rtl/decode_pkg.sv | 51 +++++
 rtl/decode_regfile.sv | 36 +++
 rtl/decode.sv | 74 +++++++
 tb/tb_decode.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared constants and control decoding for the instruction-decode stage.
package decode_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 16;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h8;
  localparam logic [3:0] OP_SUBI = 4'hA;
  localparam logic [3:0] OP_LDI  = 4'hC;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  // Control bundle derived purely from the opcode field.
  typedef struct packed {
    alu_op_e aluc;
    logic    selc_b;
    logic    we;
    logic    zero_a;
  } ctrl_t;

  // Opcode to control mapping; anything unrecognised behaves as a NOP.
  function automatic ctrl_t decode_op(input logic [3:0] op);
    ctrl_t c;
    c.aluc   = ALU_ADD;
    c.selc_b = 1'b0;
    c.we     = 1'b0;
    c.zero_a = 1'b0;
    case (op)
      OP_ADD:  begin c.aluc = ALU_ADD; c.we = 1'b1; end
      OP_SUB:  begin c.aluc = ALU_SUB; c.we = 1'b1; end
      OP_AND:  begin c.aluc = ALU_AND; c.we = 1'b1; end
      OP_OR:   begin c.aluc = ALU_OR;  c.we = 1'b1; end
      OP_ADDI: begin c.aluc = ALU_ADD; c.selc_b = 1'b1; c.we = 1'b1; end
      OP_SUBI: begin c.aluc = ALU_SUB; c.selc_b = 1'b1; c.we = 1'b1; end
      OP_LDI:  begin c.aluc = ALU_ADD; c.selc_b = 1'b1; c.we = 1'b1; c.zero_a = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// 16x16 general register file: one write port, two combinational read
// ports that forward the incoming write data when addresses collide.
module decode_regfile
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wer,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  // Register storage: cleared on reset, written from writeback otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wer) begin
      regs[waddr] <= wdata;
    end
  end

  // Reads forward same-cycle writeback data so decode never sees a stale value.
  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
    if (wer && (waddr == raddr_a)) rdata_a = wdata;
    if (wer && (waddr == raddr_b)) rdata_b = wdata;
  end

endmodule

// File: rtl/decode.sv
// Instruction-decode stage: reads operands, decodes control and registers
// everything into the ID/EX pipeline register.
module decode
  import decode_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] inst,
  input  logic              wer,
  input  logic [ADDR_W-1:0] rdestrr,
  input  logic [DATA_W-1:0] s2,
  output logic [DATA_W-1:0] s0,
  output logic [DATA_W-1:0] rdo1,
  output logic [DATA_W-1:0] imme,
  output logic [1:0]        aluc,
  output logic              selc_b,
  output logic              we,
  output logic [ADDR_W-1:0] rdestr
);

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rs_addr;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] rs_data;
  ctrl_t             ctrl;
  logic [DATA_W-1:0] a_next;

  assign opcode  = inst[15:12];
  assign rd_addr = inst[11:8];
  assign rs_addr = inst[7:4];
  assign imm8    = inst[7:0];

  decode_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wer     (wer),
    .waddr   (rdestrr),
    .wdata   (s2),
    .raddr_a (rd_addr),
    .raddr_b (rs_addr),
    .rdata_a (rd_data),
    .rdata_b (rs_data)
  );

  // Control decode, with operand A zeroed for LDI so the ALU yields 0 + imm.
  always_comb begin
    ctrl   = decode_op(opcode);
    a_next = ctrl.zero_a ? '0 : rd_data;
  end

  // ID/EX pipeline register; reset state is indistinguishable from a NOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0     <= '0;
      rdo1   <= '0;
      imme   <= '0;
      aluc   <= 2'b00;
      selc_b <= 1'b0;
      we     <= 1'b0;
      rdestr <= '0;
    end else begin
      s0     <= a_next;
      rdo1   <= rs_data;
      imme   <= {8'h00, imm8};
      aluc   <= ctrl.aluc;
      selc_b <= ctrl.selc_b;
      we     <= ctrl.we;
      rdestr <= rd_addr;
    end
  end

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for the decode stage: table vectors, hand-written
// reset sequences and a randomised run against a reference register model.
module tb_decode;

  typedef struct packed {
    logic [15:0] s0;
    logic [15:0] rdo1;
    logic [15:0] imme;
    logic [1:0]  aluc;
    logic        selc_b;
    logic        we;
    logic [3:0]  rdestr;
  } out_t;

  typedef struct packed {
    logic [15:0] inst;
    logic        wer;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    out_t        exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] inst;
  logic        wer;
  logic [3:0]  rdestrr;
  logic [15:0] s2;
  logic [15:0] s0;
  logic [15:0] rdo1;
  logic [15:0] imme;
  logic [1:0]  aluc;
  logic        selc_b;
  logic        we;
  logic [3:0]  rdestr;

  int checks = 0;
  int errors = 0;

  out_t        sb_q[$];
  logic [15:0] mregs [16];
  vec_t        vecs [15];

  decode dut (
    .clk     (clk),
    .rst     (rst),
    .inst    (inst),
    .wer     (wer),
    .rdestrr (rdestrr),
    .s2      (s2),
    .s0      (s0),
    .rdo1    (rdo1),
    .imme    (imme),
    .aluc    (aluc),
    .selc_b  (selc_b),
    .we      (we),
    .rdestr  (rdestr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic out_t mk_out(input logic [15:0] a, input logic [15:0] b,
                                  input logic [15:0] im, input logic [1:0] op,
                                  input logic sb, input logic w, input logic [3:0] rd);
    out_t o;
    o.s0 = a; o.rdo1 = b; o.imme = im; o.aluc = op;
    o.selc_b = sb; o.we = w; o.rdestr = rd;
    return o;
  endfunction

  function automatic vec_t mk_vec(input logic [15:0] i, input logic w, input logic [3:0] wa,
                                  input logic [15:0] wd, input out_t e);
    vec_t v;
    v.inst = i; v.wer = w; v.waddr = wa; v.wdata = wd; v.exp = e;
    return v;
  endfunction

  // Independent reference: opcode table plus bench-side register array.
  function automatic out_t model(input logic [15:0] i, input logic w,
                                 input logic [3:0] wa, input logic [15:0] wd);
    out_t o;
    logic [15:0] a;
    logic [15:0] b;
    a = (w && wa == i[11:8]) ? wd : mregs[i[11:8]];
    b = (w && wa == i[7:4])  ? wd : mregs[i[7:4]];
    o = mk_out(a, b, {8'h00, i[7:0]}, 2'b00, 1'b0, 1'b0, i[11:8]);
    case (i[15:12])
      4'h1: o.we = 1'b1;
      4'h2: begin o.aluc = 2'b01; o.we = 1'b1; end
      4'h3: begin o.aluc = 2'b10; o.we = 1'b1; end
      4'h4: begin o.aluc = 2'b11; o.we = 1'b1; end
      4'h8: begin o.selc_b = 1'b1; o.we = 1'b1; end
      4'hA: begin o.aluc = 2'b01; o.selc_b = 1'b1; o.we = 1'b1; end
      4'hC: begin o.s0 = 16'h0000; o.selc_b = 1'b1; o.we = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic cmp(input string name, input int tag, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s (vec %0d): got %h expected %h", name, tag, got, exp);
    end
  endtask

  task automatic checkOutput(input int tag);
    out_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard (vec %0d): got empty queue expected entry", tag);
      return;
    end
    e = sb_q.pop_front();
    cmp("s0", tag, s0, e.s0);
    cmp("rdo1", tag, rdo1, e.rdo1);
    cmp("imme", tag, imme, e.imme);
    cmp("aluc", tag, {14'd0, aluc}, {14'd0, e.aluc});
    cmp("selc_b", tag, {15'd0, selc_b}, {15'd0, e.selc_b});
    cmp("we", tag, {15'd0, we}, {15'd0, e.we});
    cmp("rdestr", tag, {12'd0, rdestr}, {12'd0, e.rdestr});
  endtask

  task automatic applyStimulus(input logic [15:0] i, input logic w, input logic [3:0] wa,
                               input logic [15:0] wd, input out_t e, input int tag);
    @(negedge clk);
    inst = i; wer = w; rdestrr = wa; s2 = wd;
    sb_q.push_back(e);
    @(posedge clk);
    if (w) mregs[wa] = wd;
    #1;
    checkOutput(tag);
  endtask

  task automatic checkReset(input int tag);
    sb_q.push_back(mk_out(16'h0, 16'h0, 16'h0, 2'b00, 1'b0, 1'b0, 4'h0));
    checkOutput(tag);
  endtask

  initial begin
    for (int r = 0; r < 16; r++) mregs[r] = 16'h0000;

    vecs[0]  = mk_vec(16'h0000, 1'b0, 4'h0, 16'h0000, mk_out(16'h0000, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 4'h0));
    vecs[1]  = mk_vec(16'h0000, 1'b1, 4'h0, 16'hAAAA, mk_out(16'hAAAA, 16'hAAAA, 16'h0000, 2'b00, 1'b0, 1'b0, 4'h0));
    vecs[2]  = mk_vec(16'h0000, 1'b1, 4'h1, 16'hBBBB, mk_out(16'hAAAA, 16'hAAAA, 16'h0000, 2'b00, 1'b0, 1'b0, 4'h0));
    vecs[3]  = mk_vec(16'h1010, 1'b0, 4'h0, 16'h0000, mk_out(16'hAAAA, 16'hBBBB, 16'h0010, 2'b00, 1'b0, 1'b1, 4'h0));
    vecs[4]  = mk_vec(16'hC188, 1'b0, 4'h0, 16'h0000, mk_out(16'h0000, 16'h0000, 16'h0088, 2'b00, 1'b1, 1'b1, 4'h1));
    vecs[5]  = mk_vec(16'hA148, 1'b0, 4'h0, 16'h0000, mk_out(16'hBBBB, 16'h0000, 16'h0048, 2'b01, 1'b1, 1'b1, 4'h1));
    vecs[6]  = mk_vec(16'h4320, 1'b1, 4'h2, 16'h1234, mk_out(16'h0000, 16'h1234, 16'h0020, 2'b11, 1'b0, 1'b1, 4'h3));
    vecs[7]  = mk_vec(16'h1230, 1'b0, 4'h0, 16'h0000, mk_out(16'h1234, 16'h0000, 16'h0030, 2'b00, 1'b0, 1'b1, 4'h2));
    vecs[8]  = mk_vec(16'hF123, 1'b0, 4'h0, 16'h0000, mk_out(16'hBBBB, 16'h1234, 16'h0023, 2'b00, 1'b0, 1'b0, 4'h1));
    vecs[9]  = mk_vec(16'h2010, 1'b0, 4'h0, 16'h0000, mk_out(16'hAAAA, 16'hBBBB, 16'h0010, 2'b01, 1'b0, 1'b1, 4'h0));
    vecs[10] = mk_vec(16'h3120, 1'b0, 4'h0, 16'h0000, mk_out(16'hBBBB, 16'h1234, 16'h0020, 2'b10, 1'b0, 1'b1, 4'h1));
    vecs[11] = mk_vec(16'h8205, 1'b0, 4'h0, 16'h0000, mk_out(16'h1234, 16'hAAAA, 16'h0005, 2'b00, 1'b1, 1'b1, 4'h2));
    vecs[12] = mk_vec(16'hC0FF, 1'b1, 4'h0, 16'h5555, mk_out(16'h0000, 16'h0000, 16'h00FF, 2'b00, 1'b1, 1'b1, 4'h0));
    vecs[13] = mk_vec(16'h1000, 1'b0, 4'h0, 16'h0000, mk_out(16'h5555, 16'h5555, 16'h0000, 2'b00, 1'b0, 1'b1, 4'h0));
    vecs[14] = mk_vec(16'h9123, 1'b0, 4'h0, 16'h0000, mk_out(16'hBBBB, 16'h1234, 16'h0023, 2'b00, 1'b0, 1'b0, 4'h1));

    // Power-on reset with busy inputs: outputs must stay cleared across edges.
    rst = 1'b0; inst = 16'h1111; wer = 1'b1; rdestrr = 4'h5; s2 = 16'hFFFF;
    #2;
    checkReset(100);
    @(posedge clk); #1;
    checkReset(101);
    @(negedge clk);
    inst = 16'h0000; wer = 1'b0; rdestrr = 4'h0; s2 = 16'h0000;
    rst = 1'b1;

    for (int v = 0; v < 15; v++)
      applyStimulus(vecs[v].inst, vecs[v].wer, vecs[v].waddr, vecs[v].wdata, vecs[v].exp, v);

    // Mid-run reset clears outputs at once and wipes the register file.
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkReset(200);
    @(negedge clk);
    for (int r = 0; r < 16; r++) mregs[r] = 16'h0000;
    rst = 1'b1;
    applyStimulus(16'h1010, 1'b0, 4'h0, 16'h0000,
                  mk_out(16'h0000, 16'h0000, 16'h0010, 2'b00, 1'b0, 1'b1, 4'h0), 201);
    applyStimulus(16'h4210, 1'b0, 4'h0, 16'h0000,
                  mk_out(16'h0000, 16'h0000, 16'h0010, 2'b11, 1'b0, 1'b1, 4'h2), 202);

    // Randomised traffic checked against the reference model.
    for (int n = 0; n < 200; n++) begin
      logic [15:0] ri;
      logic        rw;
      logic [3:0]  ra;
      logic [15:0] rdat;
      ri   = 16'($urandom);
      rw   = 1'($urandom_range(0, 1));
      ra   = 4'($urandom_range(0, 15));
      rdat = 16'($urandom);
      applyStimulus(ri, rw, ra, rdat, model(ri, rw, ra, rdat), 300 + n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
